// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Requester-side bus of the data-memory arbiter. One instance
//                per requester (CPU memory stage, program/debug loader).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
) ();

    // Request payload, driven by the requester
    logic                  req;       // request valid
    logic                  we;        // 1 = store, 0 = load
    logic                  byte_sel;  // 1 = byte access (SB/LBU), 0 = word
    logic [DATA_WIDTH-1:0] addr;      // byte address
    logic [DATA_WIDTH-1:0] wd;        // store data, byte stores use [7:0]

    // Handshake and response, driven by the arbiter
    logic                  gnt;       // request accepted this cycle
    logic                  rvalid;    // response valid
    logic                  rerr;      // response is an error
    logic [DATA_WIDTH-1:0] rd;        // load data, byte loads zero-extended

    modport master (
        output req, we, byte_sel, addr, wd,
        input  gnt, rvalid, rerr, rd
    );

    modport slave (
        input  req, we, byte_sel, addr, wd,
        output gnt, rvalid, rerr, rd
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-port byte-addressed data memory between
//                the CPU memory stage and the loader. Round-robin on
//                conflicts, optional loader lock with a bounded length and a
//                CPU-priority cooldown cycle, alignment/range checking and
//                registered one-cycle-latency responses per requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 17,
    parameter int MAX_LOCK   = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,

    dmem_arbiter_if.slave              cpu,
    dmem_arbiter_if.slave              ldr,
    input  wire logic                  ldr_lock,

    output logic                       mem_we,
    output logic                       mem_st_src,
    output logic                       mem_ld_src,
    output logic [DATA_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wd,
    input  wire logic [DATA_WIDTH-1:0] mem_rd
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // First illegal byte address, one bit wider than an address so the
    // last-byte computation of a word access near 2**32 cannot wrap.
    localparam logic [DATA_WIDTH:0] c_mem_limit = (DATA_WIDTH+1)'(1) << ADDR_BITS;
    localparam logic [7:0]          c_max_lock  = 8'(MAX_LOCK);
    localparam logic                c_port_cpu  = 1'b0;
    localparam logic                c_port_ldr  = 1'b1;

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t    state_q,     state_d;
    logic      rr_last_q,   rr_last_d;    // port that won the last conflict
    logic [7:0] lock_cnt_q, lock_cnt_d;   // loader-owned cycles in this lock

    logic                  cpu_rvalid_q, ldr_rvalid_q;
    logic                  cpu_rerr_q,   ldr_rerr_q;
    logic [DATA_WIDTH-1:0] cpu_rd_q,     ldr_rd_q;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_cpu_gnt;
    logic                  w_ldr_gnt;
    logic [7:0]            w_cnt_inc;
    logic                  w_cpu_err;
    logic                  w_ldr_err;

    logic                  w_sel_we;
    logic                  w_sel_byte;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wd;
    logic [DATA_WIDTH-1:0] w_resp_rd;

    // A word must be 4-byte aligned; the last byte touched must lie inside
    // the memory.
    function automatic logic addr_err(input logic                  is_byte,
                                      input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH:0] last_byte;
        last_byte = {1'b0, addr} + {{(DATA_WIDTH-1){1'b0}}, ~is_byte, ~is_byte};
        return (!is_byte && (addr[1:0] != 2'b00)) || (last_byte >= c_mem_limit);
    endfunction

    assign w_cpu_err = addr_err(cpu.byte_sel, cpu.addr);
    assign w_ldr_err = addr_err(ldr.byte_sel, ldr.addr);

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            rr_last_q  <= c_port_ldr;   // CPU wins the first conflict
            lock_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Grant decision and next arbitration state
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_ldr_gnt  = 1'b0;
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_cnt_d = lock_cnt_q;
        w_cnt_inc  = lock_cnt_q + 8'd1;

        if (rst_n) begin
            case (state_q)
                ST_ARB: begin
                    if (cpu.req && ldr.req) begin
                        if (rr_last_q == c_port_ldr) begin
                            w_cpu_gnt = 1'b1;
                            rr_last_d = c_port_cpu;
                        end else begin
                            w_ldr_gnt = 1'b1;
                            rr_last_d = c_port_ldr;
                        end
                    end else begin
                        w_cpu_gnt = cpu.req;
                        w_ldr_gnt = ldr.req;
                    end
                    // A lock only starts on a cycle the loader actually wins
                    if (w_ldr_gnt && ldr_lock) begin
                        state_d    = ST_LOCKED;
                        lock_cnt_d = 8'd1;
                    end
                end

                ST_LOCKED: begin
                    w_ldr_gnt  = ldr.req;
                    lock_cnt_d = w_cnt_inc;
                    // The count includes the cycle that opened the lock, so
                    // the loader owns the memory for at most MAX_LOCK cycles.
                    if (!ldr_lock || (w_cnt_inc >= c_max_lock)) begin
                        state_d = ST_COOLDOWN;
                    end
                end

                ST_COOLDOWN: begin
                    w_cpu_gnt = cpu.req;
                    w_ldr_gnt = ldr.req && !cpu.req;
                    state_d   = ST_ARB;
                    if (w_cpu_gnt) begin
                        rr_last_d = c_port_cpu;
                    end else if (w_ldr_gnt) begin
                        rr_last_d = c_port_ldr;
                    end
                end

                default: begin
                    state_d = ST_ARB;
                end
            endcase
        end
    end

    // Memory drive from the granted port, response data from the memory
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_byte = 1'b0;
        w_sel_err  = 1'b0;
        w_sel_addr = '0;
        w_sel_wd   = '0;

        if (w_cpu_gnt) begin
            w_sel_we   = cpu.we;
            w_sel_byte = cpu.byte_sel;
            w_sel_err  = w_cpu_err;
            w_sel_addr = cpu.addr;
            w_sel_wd   = cpu.wd;
        end else if (w_ldr_gnt) begin
            w_sel_we   = ldr.we;
            w_sel_byte = ldr.byte_sel;
            w_sel_err  = w_ldr_err;
            w_sel_addr = ldr.addr;
            w_sel_wd   = ldr.wd;
        end

        // Errored requests are consumed but never reach the memory array
        mem_we     = w_sel_we && !w_sel_err;
        mem_st_src = w_sel_byte;
        mem_ld_src = w_sel_byte;
        mem_addr   = w_sel_err ? '0 : w_sel_addr;
        mem_wd     = w_sel_wd;

        if (w_sel_err || w_sel_we) begin
            w_resp_rd = '0;
        end else if (w_sel_byte) begin
            w_resp_rd = {{(DATA_WIDTH-8){1'b0}}, mem_rd[7:0]};
        end else begin
            w_resp_rd = mem_rd;
        end
    end

    // Per-port response registers; rd/rerr hold until the next response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            cpu_rerr_q   <= 1'b0;
            cpu_rd_q     <= '0;
            ldr_rvalid_q <= 1'b0;
            ldr_rerr_q   <= 1'b0;
            ldr_rd_q     <= '0;
        end else begin
            cpu_rvalid_q <= w_cpu_gnt;
            ldr_rvalid_q <= w_ldr_gnt;
            if (w_cpu_gnt) begin
                cpu_rerr_q <= w_sel_err;
                cpu_rd_q   <= w_resp_rd;
            end
            if (w_ldr_gnt) begin
                ldr_rerr_q <= w_sel_err;
                ldr_rd_q   <= w_resp_rd;
            end
        end
    end

    assign cpu.gnt    = w_cpu_gnt;
    assign cpu.rvalid = cpu_rvalid_q;
    assign cpu.rerr   = cpu_rerr_q;
    assign cpu.rd     = cpu_rd_q;

    assign ldr.gnt    = w_ldr_gnt;
    assign ldr.rvalid = ldr_rvalid_q;
    assign ldr.rerr   = ldr_rerr_q;
    assign ldr.rd     = ldr_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a behavioural
//                memory, a reference model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW   = 32;
    localparam int AB   = 17;
    localparam int ML   = 4;
    localparam int MEMB = 1 << AB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          ldr_lock;
    logic          mem_we, mem_st_src, mem_ld_src;
    logic [DW-1:0] mem_addr, mem_wd, mem_rd;

    dmem_arbiter_if #(.DATA_WIDTH(DW)) cpu_if ();
    dmem_arbiter_if #(.DATA_WIDTH(DW)) ldr_if ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .MAX_LOCK(ML)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (cpu_if),
        .ldr        (ldr_if),
        .ldr_lock   (ldr_lock),
        .mem_we     (mem_we),
        .mem_st_src (mem_st_src),
        .mem_ld_src (mem_ld_src),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // ---------------- physical memory (environment) ----------------
    bit   [7:0]  phys [0:MEMB-1];
    logic [AB-1:0] ma;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_st_src) begin
                phys[mem_addr[AB-1:0]] <= mem_wd[7:0];
            end else begin
                phys[mem_addr[AB-1:0]]             <= mem_wd[7:0];
                phys[AB'(mem_addr[AB-1:0] + 17'd1)] <= mem_wd[15:8];
                phys[AB'(mem_addr[AB-1:0] + 17'd2)] <= mem_wd[23:16];
                phys[AB'(mem_addr[AB-1:0] + 17'd3)] <= mem_wd[31:24];
            end
        end
    end

    always_comb begin
        ma = mem_addr[AB-1:0];
        if (mem_ld_src) mem_rd = {24'h0, phys[ma]};
        else            mem_rd = {phys[AB'(ma + 17'd3)], phys[AB'(ma + 17'd2)],
                                  phys[AB'(ma + 17'd1)], phys[ma]};
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    typedef struct { int due; logic err; logic [31:0] rd; } resp_t;
    typedef struct { logic req; logic we; logic by; logic [31:0] addr; logic [31:0] wd; } rq_t;

    resp_t cq[$];
    resp_t lq[$];

    // ---------------- reference model ----------------
    bit [7:0] mm [0:MEMB-1];     // model memory contents
    bit       m_rr_ldr;          // loader won the last conflict
    bit       m_locked;          // loader owns the memory
    bit       m_cool;            // one CPU-priority cycle after a lock
    int       m_used;            // loader-owned cycles in the current lock

    rq_t  cp, lp;
    logic rstn_v, lock_v;
    bit   eg_c, eg_l;
    bit   mon_en = 0;
    logic [31:0] c_hold_rd = 0, l_hold_rd = 0;
    logic        c_hold_err = 0, l_hold_err = 0;

    function automatic rq_t mk(bit req, bit we, bit by, logic [31:0] a, logic [31:0] d);
        rq_t r;
        r.req = req; r.we = we; r.by = by; r.addr = a; r.wd = d;
        return r;
    endfunction

    function automatic bit is_err(rq_t r);
        longint a;
        a = longint'(r.addr);
        return (!r.by && (a % 4 != 0)) || (a + (r.by ? 0 : 3) >= MEMB);
    endfunction

    function automatic logic [31:0] mload(rq_t r);
        int a;
        a = int'(r.addr);
        if (r.by) return {24'h0, mm[a]};
        return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endfunction

    task automatic model_access(input rq_t r, input bit is_cpu);
        resp_t x;
        int    a;
        x.due = cyc + 1;
        x.err = is_err(r);
        x.rd  = (x.err || r.we) ? 32'h0 : mload(r);
        if (!x.err && r.we) begin
            a = int'(r.addr);
            mm[a] = r.wd[7:0];
            if (!r.by) begin
                mm[a+1] = r.wd[15:8];
                mm[a+2] = r.wd[23:16];
                mm[a+3] = r.wd[31:24];
            end
        end
        if (is_cpu) cq.push_back(x);
        else        lq.push_back(x);
    endtask

    // One clock cycle: drive inputs, predict grants and memory drive, check
    // them, record expected responses and advance the model.
    task automatic step();
        rq_t sel;
        bit  any, e;
        @(negedge clk);
        rst_n           = rstn_v;
        ldr_lock        = lock_v;
        cpu_if.req      = cp.req;  cpu_if.we = cp.we;  cpu_if.byte_sel = cp.by;
        cpu_if.addr     = cp.addr; cpu_if.wd = cp.wd;
        ldr_if.req      = lp.req;  ldr_if.we = lp.we;  ldr_if.byte_sel = lp.by;
        ldr_if.addr     = lp.addr; ldr_if.wd = lp.wd;
        #1;
        eg_c = 0; eg_l = 0;
        if (rstn_v) begin
            if (m_cool)                  begin eg_c = cp.req; eg_l = lp.req && !cp.req; end
            else if (m_locked)           eg_l = lp.req;
            else if (cp.req && lp.req)   begin eg_c = m_rr_ldr; eg_l = !m_rr_ldr; end
            else                         begin eg_c = cp.req; eg_l = lp.req; end
        end
        chk("cpu_gnt", cpu_if.gnt, eg_c);
        chk("ldr_gnt", ldr_if.gnt, eg_l);

        sel = eg_c ? cp : lp;
        any = eg_c || eg_l;
        e   = any && is_err(sel);
        chk("mem_we",   mem_we, any && sel.we && !e);
        chk("mem_addr", mem_addr, (!any || e) ? 32'h0 : sel.addr);
        chk("mem_wd",   mem_wd, any ? sel.wd : 32'h0);
        chk("mem_src",  {mem_st_src, mem_ld_src}, any ? {sel.by, sel.by} : 2'b00);

        if (eg_c) model_access(cp, 1'b1);
        if (eg_l) model_access(lp, 1'b0);

        if (!rstn_v) begin
            m_rr_ldr = 1; m_locked = 0; m_cool = 0; m_used = 0;
            c_hold_rd = 0; c_hold_err = 0; l_hold_rd = 0; l_hold_err = 0;
        end else if (m_cool) begin
            m_cool = 0;
            if (eg_c)      m_rr_ldr = 0;
            else if (eg_l) m_rr_ldr = 1;
        end else if (m_locked) begin
            m_used++;
            if (!lock_v || m_used >= ML) begin m_locked = 0; m_cool = 1; end
        end else begin
            if (cp.req && lp.req) m_rr_ldr = eg_l;
            if (eg_l && lock_v) begin m_locked = 1; m_used = 1; end
        end
    endtask

    task automatic gnt_is(input string nm, input bit ec, input bit el);
        chk({nm, "_cpu"}, cpu_if.gnt, ec);
        chk({nm, "_ldr"}, ldr_if.gnt, el);
    endtask

    function automatic rq_t rand_rq();
        rq_t r;
        int  k;
        r.req = ($urandom % 3) != 0;
        r.we  = $urandom % 2;
        r.by  = ($urandom % 3) == 0;
        r.wd  = $urandom;
        k     = $urandom_range(0, 9);
        if (k < 7)       r.addr = 32'h10000 + $urandom_range(0, 31);
        else if (k == 7) r.addr = 32'h1FFF8 + $urandom_range(0, 7);
        else if (k == 8) r.addr = 32'h20000 + $urandom_range(0, 3);
        else             r.addr = $urandom;
        if (!r.by && ($urandom % 4 != 0)) r.addr[1:0] = 2'b00;
        return r;
    endfunction

    // ---------------- response monitor / scoreboard ----------------
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ev = (cq.size() > 0) && (cq[0].due == cyc);
                chk("cpu_rvalid", cpu_if.rvalid, ev);
                if (ev) begin
                    c_hold_rd = cq[0].rd; c_hold_err = cq[0].err;
                    void'(cq.pop_front());
                end
                chk("cpu_rd",   cpu_if.rd,   c_hold_rd);
                chk("cpu_rerr", cpu_if.rerr, c_hold_err);

                ev = (lq.size() > 0) && (lq[0].due == cyc);
                chk("ldr_rvalid", ldr_if.rvalid, ev);
                if (ev) begin
                    l_hold_rd = lq[0].rd; l_hold_err = lq[0].err;
                    void'(lq.pop_front());
                end
                chk("ldr_rd",   ldr_if.rd,   l_hold_rd);
                chk("ldr_rerr", ldr_if.rerr, l_hold_err);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit exp_l4 [9] = '{0, 1, 1, 1, 1, 0, 1, 0, 1};
        bit exp_l5 [5] = '{0, 1, 1, 1, 0};

        m_rr_ldr = 1; m_locked = 0; m_cool = 0; m_used = 0;
        lock_v = 0;
        rstn_v = 0;

        // Reset held with both ports requesting
        cp = mk(1, 0, 0, 32'h10000, 0);
        lp = mk(1, 0, 0, 32'h10008, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1;
            gnt_is("rst_gnt", 0, 0);
            chk("rst_mem_we", mem_we, 0);
        end
        rstn_v = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            gnt_is("rr_alt", (i % 2) == 0, (i % 2) == 1);
        end

        // Word round trip and byte load
        lp.req = 0;
        cp = mk(1, 1, 0, 32'h10004, 32'hDEADBEEF); step();
        cp = mk(1, 0, 0, 32'h10004, 0);            step();
        cp = mk(1, 0, 1, 32'h10006, 0);            step();
        chk("lw_rd", cpu_if.rd, 32'hDEADBEEF);
        cp.req = 0;                                step();
        chk("lbu_rd", cpu_if.rd, 32'h000000AD);

        // Alignment and range errors
        cp = mk(1, 0, 0, 32'h10002, 0);            step();
        chk("lw_mis_we", mem_we, 0);
        cp = mk(1, 1, 0, 32'h1FFFE, 32'h12345678); step();
        chk("lw_mis_rerr", cpu_if.rerr, 1);
        chk("lw_mis_rd",   cpu_if.rd,   0);
        chk("sw_oor_we",   mem_we,      0);
        cp = mk(1, 1, 1, 32'h1FFFF, 32'h000000A5); step();
        chk("sw_oor_rerr", cpu_if.rerr, 1);
        cp = mk(1, 0, 1, 32'h1FFFF, 0);            step();
        chk("sb_end_rerr", cpu_if.rerr, 0);
        chk("sw_oor_mem",  {phys[32'h1FFFE], phys[32'h1FFFF]}, 16'h00A5);
        cp.req = 0;                                step();
        chk("lbu_end_rd",  cpu_if.rd, 32'h000000A5);

        // Lock cap: at most ML loader-owned cycles, then a CPU cooldown grant
        rstn_v = 0; cp.req = 0; lp.req = 0; step(); rstn_v = 1;
        cp = mk(1, 0, 0, 32'h10000, 0);
        lp = mk(1, 0, 0, 32'h10008, 0);
        lock_v = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) lock_v = 0;
            step();
            gnt_is("lockcap", !exp_l4[i], exp_l4[i]);
        end

        // Lock released early
        rstn_v = 0; step(); rstn_v = 1;
        lock_v = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) lock_v = 0;
            step();
            gnt_is("lockrel", !exp_l5[i], exp_l5[i]);
        end

        // Loader load presented while reset is asserted produces no response
        cp.req = 0;
        lp = mk(1, 0, 0, 32'h10004, 0);
        rstn_v = 0; step();
        gnt_is("rst_mid", 0, 0);
        rstn_v = 1; step();
        chk("rst_mid_rvalid", ldr_if.rvalid, 0);
        lp.req = 0; step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn_v = ($urandom % 250) != 0;
            if ($urandom % 6 == 0) lock_v = ~lock_v;
            step();
            if (!(cp.req && !eg_c)) cp = rand_rq();
            if (!(lp.req && !eg_l)) lp = rand_rq();
        end

        cp.req = 0; lp.req = 0; lock_v = 0; rstn_v = 1;
        repeat (3) step();
        chk("cpu_queue_drained", cq.size(), 0);
        chk("ldr_queue_drained", lq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
